ramp_conversion_ctrl: RTL and testbench
=======================================

RAMP_CONVERSION_CTRL -- requirements
Module: ramp_conversion_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, giving the width of the DAC code and the result.
REQ-002 SHALL have parameter STEP_CYCLES, default 4, giving the clocks each DAC code is held (DAC settle plus comparator time); legal range 1..255.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request one conversion; sampled on the clock edge.
REQ-006 SHALL have port capture_en, input, 1 bit: one-clock pulse from the comparator capture stage when the comparator falls.
REQ-007 SHALL have port dac_code, output, DATA_W bits: ramp code driven to the external DAC.
REQ-008 SHALL have port dac_load, output, 1 bit: one-clock strobe, asserted in the first cycle each new dac_code is valid.
REQ-009 SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-010 SHALL have port result, output, DATA_W bits: last converted code, held until the next completion.
REQ-011 SHALL have port result_valid, output, 1 bit: one-clock completion strobe.
REQ-012 SHALL have port overrange, output, 1 bit: set with result_valid when the ramp ends without a capture; cleared at the next completion.

Function
REQ-013 SHALL implement the states IDLE, RAMP and DONE.
REQ-014 In IDLE, start=1 SHALL move the block to RAMP on the next cycle with dac_code=0, dac_load=1, busy=1 and the step timer cleared.
REQ-015 In RAMP, each code SHALL be held exactly STEP_CYCLES cycles; on the last cycle of a step, dac_code increments and dac_load pulses in the following cycle.
REQ-016 In RAMP, capture_en=1 in any cycle SHALL latch result=dac_code (the current code, not the incremented code) and move the block to DONE.
REQ-017 If capture_en=1 coincides with the last cycle of a step, the capture SHALL win: result is the current code and no increment or dac_load occurs.
REQ-018 If the last cycle of code 2^DATA_W-1 elapses with no capture, the block SHALL set result to all ones and overrange=1, then move to DONE; dac_code SHALL NOT wrap to 0 during RAMP.
REQ-019 DONE SHALL last one cycle and assert result_valid=1, busy=0 and dac_code=0; it then SHALL move to IDLE. The result_valid and overrange updates SHALL be registered.
REQ-020 capture_en SHALL be ignored in IDLE and DONE.
REQ-021 start SHALL be ignored while busy=1 and in DONE, with no queuing.
REQ-022 Latency: a capture in cycle t SHALL give result_valid=1 in cycle t+1.
REQ-023 Nominal full-scale conversion time SHALL be 1 + 2^DATA_W * STEP_CYCLES + 1 cycles from the start sample to result_valid.
REQ-024 The step timer SHALL be ceil(log2(STEP_CYCLES+1)) bits wide. The code counter SHALL be DATA_W bits, with the terminal code detected by compare, not by carry.

Reset
REQ-025 Reset assertion SHALL asynchronously force the state to IDLE and set dac_code=0, dac_load=0, busy=0, result=0, result_valid=0, overrange=0 and the timers to 0.
REQ-026 Reset asserted during RAMP SHALL abort the conversion with no result_valid pulse; the next start after release SHALL begin a fresh conversion from code 0.
REQ-027 Reset deassertion SHALL be assumed synchronous to clk externally; no internal synchronizer is required.

Structure
REQ-028 The state enum typedef and the default DATA_W/STEP_CYCLES constants SHALL live in the shared package adc_pkg, alongside the other ADC blocks.
REQ-029 The block SHALL be a single module with no sub-module; the step timer and code counter are inline.
REQ-030 The block SHALL connect to comparator_capture's capture_en directly and SHALL NOT re-detect comparator edges.

Verification (DATA_W=8, STEP_CYCLES=4)
REQ-031 Start sampled at cycle 0, capture_en pulsed at cycle 1+37*4+2=151 -> result=37, result_valid=1 at cycle 152, overrange=0, busy low at 152.
REQ-032 capture_en pulsed on the last cycle of code 10 (cycle 44) -> result=10, no dac_load for code 11.
REQ-033 No capture_en at all -> dac_code reaches 255 without wrapping; result=255, overrange=1 and result_valid at cycle 1026.
REQ-034 start pulsed again at cycle 20 during RAMP and capture_en pulsed in IDLE -> both ignored, the single conversion completes normally, no spurious result_valid.
REQ-035 Reset asserted asynchronously mid-step at code 100 -> all outputs 0 immediately, no result_valid; a new start then gives dac_code=0 with dac_load=1.
REQ-036 Two back-to-back conversions with captures at codes 0 and 255 -> results 0 then 255, dac_load count equals codes presented, overrange=0 both times.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared ADC package: state encoding and default sizing used by the ADC
// control blocks.
package adc_pkg;

  localparam int ADC_DATA_W      = 8;
  localparam int ADC_STEP_CYCLES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    DONE = 2'd2
  } ramp_state_t;

endpackage

// File: rtl/ramp_conversion_ctrl.sv
// Single-slope ramp ADC controller: steps a DAC code upward until the
// comparator capture stage reports a crossing, then reports that code.
module ramp_conversion_ctrl
  import adc_pkg::*;
#(
  parameter int DATA_W      = ADC_DATA_W,
  parameter int STEP_CYCLES = ADC_STEP_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              capture_en,
  output logic [DATA_W-1:0] dac_code,
  output logic              dac_load,
  output logic              busy,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              overrange
);

  localparam int                  TIMER_W   = $clog2(STEP_CYCLES + 1);
  localparam logic [TIMER_W-1:0]  LAST_TICK = TIMER_W'(STEP_CYCLES - 1);
  localparam logic [DATA_W-1:0]   CODE_MAX  = '1;

  ramp_state_t        state;
  logic [TIMER_W-1:0] step_timer;
  logic               ramp_end;
  logic               step_last;

  assign step_last = (step_timer == LAST_TICK);

  // ramp_end marks the one cycle after the top code has been held in full;
  // that cycle produces the overrange result instead of wrapping the code.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      dac_code     <= '0;
      dac_load     <= 1'b0;
      busy         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      overrange    <= 1'b0;
      step_timer   <= '0;
      ramp_end     <= 1'b0;
    end else begin
      dac_load     <= 1'b0;
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= RAMP;
            dac_code   <= '0;
            dac_load   <= 1'b1;
            busy       <= 1'b1;
            step_timer <= '0;
            ramp_end   <= 1'b0;
          end
        end
        RAMP: begin
          if (capture_en || ramp_end) begin
            // A capture beats both the step increment and the overrange exit.
            result       <= capture_en ? dac_code : CODE_MAX;
            overrange    <= ~capture_en;
            result_valid <= 1'b1;
            busy         <= 1'b0;
            dac_code     <= '0;
            step_timer   <= '0;
            ramp_end     <= 1'b0;
            state        <= DONE;
          end else if (step_last) begin
            step_timer <= '0;
            if (dac_code == CODE_MAX) begin
              ramp_end <= 1'b1;
            end else begin
              dac_code <= dac_code + DATA_W'(1);
              dac_load <= 1'b1;
            end
          end else begin
            step_timer <= step_timer + TIMER_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ramp_conversion_ctrl.sv
// Self-checking bench for ramp_conversion_ctrl (DATA_W=8, STEP_CYCLES=4),
// using a scoreboard of expected conversion results.
module tb_ramp_conversion_ctrl;

  localparam int DATA_W = 8;
  localparam int STEP   = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              capture_en;
  logic [DATA_W-1:0] dac_code;
  logic              dac_load;
  logic              busy;
  logic [DATA_W-1:0] result;
  logic              result_valid;
  logic              overrange;

  typedef struct {
    int code;
    bit ovr;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  ramp_conversion_ctrl #(.DATA_W(DATA_W), .STEP_CYCLES(STEP)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .capture_en   (capture_en),
    .dac_code     (dac_code),
    .dac_load     (dac_load),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .overrange    (overrange)
  );

  always #5 clk = ~clk;

  // One conversion: start is sampled in cycle 0, outputs of cycle c are
  // checked against a step-counting model until the completion strobe.
  task automatic run_conv(input string name, input int cap_at, input int restart_at,
                          input int exp_code, input bit exp_ovr, input int exp_cyc);
    int   loads = 0;
    bit   got   = 0;
    int   shown = 0;
    int   mc;
    bit   ml;
    exp_t e;
    exp_t n;
    n.code = exp_code;
    n.ovr  = exp_ovr;
    n.cyc  = exp_cyc;
    e      = n;
    start      = 1'b1;
    capture_en = 1'b0;
    if (cap_at < 0) sb.push_back(n);
    @(posedge clk); #1;
    for (int c = 1; c <= 1100 && !got; c++) begin
      start      = (c == restart_at);
      capture_en = (c == cap_at);
      if (c == cap_at) sb.push_back(n);
      @(negedge clk);
      checks++;
      if (result_valid !== (c == exp_cyc)) begin
        errors++;
        if (shown++ < 5)
          $display("[TB] FAIL %s valid_timing: cycle %0d result_valid=%b expected %b",
                   name, c, result_valid, (c == exp_cyc));
      end
      if (result_valid === 1'b1) begin
        got = 1'b1;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL %s scoreboard: result_valid with no expected entry", name);
        end else begin
          e = sb.pop_front();
          if (result !== DATA_W'(e.code) || overrange !== e.ovr || busy !== 1'b0 ||
              dac_code !== '0 || dac_load !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s done: result=%0d ovr=%b busy=%b code=%0d load=%b expected result=%0d ovr=%b busy=0 code=0 load=0",
                     name, result, overrange, busy, dac_code, dac_load, e.code, e.ovr);
          end
        end
      end else begin
        mc = (c - 1) / STEP;
        ml = ((c - 1) % STEP == 0) && (mc <= 255);
        if (mc > 255) mc = 255;
        checks++;
        if (busy !== 1'b1 || dac_code !== DATA_W'(mc) || dac_load !== ml) begin
          errors++;
          if (shown++ < 5)
            $display("[TB] FAIL %s ramp: cycle %0d busy=%b code=%0d load=%b expected busy=1 code=%0d load=%b",
                     name, c, busy, dac_code, dac_load, mc, ml);
        end
        if (dac_load === 1'b1) loads++;
      end
      @(posedge clk); #1;
    end
    start      = 1'b0;
    capture_en = 1'b0;
    if (!got) begin
      errors++;
      $display("[TB] FAIL %s timeout: no result_valid within 1100 cycles, expected at cycle %0d",
               name, exp_cyc);
    end
    checks++;
    if (loads != exp_code + 1) begin
      errors++;
      $display("[TB] FAIL %s load_count: got %0d expected %0d", name, loads, exp_code + 1);
    end
    @(negedge clk);
    checks++;
    if (result_valid !== 1'b0 || busy !== 1'b0 || result !== DATA_W'(exp_code) ||
        overrange !== exp_ovr) begin
      errors++;
      $display("[TB] FAIL %s hold: valid=%b busy=%b result=%0d ovr=%b expected valid=0 busy=0 result=%0d ovr=%b",
               name, result_valid, busy, result, overrange, exp_code, exp_ovr);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    start      = 1'b0;
    capture_en = 1'b0;
    #1;
    checks++;
    if ({dac_code, dac_load, busy, result, result_valid, overrange} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_async: outputs=%h expected 0",
               {dac_code, dac_load, busy, result, result_valid, overrange});
    end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({dac_code, dac_load, busy, result, result_valid, overrange} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_release: outputs=%h expected 0",
               {dac_code, dac_load, busy, result, result_valid, overrange});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_capture_mid();
    run_conv("capture_37", 151, -1, 37, 1'b0, 152);
  endtask

  task automatic test_capture_step_end();
    run_conv("capture_step_end_10", 44, -1, 10, 1'b0, 45);
  endtask

  task automatic test_ignore_inputs();
    capture_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (result_valid !== 1'b0 || busy !== 1'b0 || dac_code !== '0 || result !== 8'd10) begin
        errors++;
        $display("[TB] FAIL idle_capture: valid=%b busy=%b code=%0d result=%0d expected 0 0 0 10",
                 result_valid, busy, dac_code, result);
      end
      @(posedge clk); #1;
    end
    capture_en = 1'b0;
    run_conv("restart_ignored", 101, 20, 25, 1'b0, 102);
  endtask

  task automatic test_overrange();
    run_conv("overrange", -1, -1, 255, 1'b1, 1026);
  endtask

  task automatic test_reset_abort();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (401) @(posedge clk);
    #3;
    checks++;
    if (dac_code !== 8'd100 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_pre: code=%0d busy=%b expected 100 1", dac_code, busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({dac_code, dac_load, busy, result, result_valid, overrange} !== '0) begin
      errors++;
      $display("[TB] FAIL abort_async: outputs=%h expected 0",
               {dac_code, dac_load, busy, result, result_valid, overrange});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (result_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL abort_quiet: valid=%b busy=%b expected 0 0", result_valid, busy);
      end
      @(posedge clk); #1;
    end
    run_conv("after_abort", 14, -1, 3, 1'b0, 15);
  endtask

  task automatic test_back_to_back();
    run_conv("b2b_code0", 1, -1, 0, 1'b0, 2);
    run_conv("b2b_code255", 1022, -1, 255, 1'b0, 1023);
  endtask

  initial begin
    test_reset();
    test_capture_mid();
    test_capture_step_end();
    test_ignore_inputs();
    test_overrange();
    test_reset_abort();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
